// File: rtl/eth_frame_filter_pkg.sv
// Shared Ethernet definitions for the receive-side frame filter.
// MAC/ethertype widths, the broadcast address and the filter state encoding.
package eth_frame_filter_pkg;

    localparam int MAC_W  = 48;
    localparam int TYPE_W = 16;

    localparam logic [MAC_W-1:0] ETH_BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORWARD = 2'd1,
        DROP    = 2'd2
    } filt_state_e;

    // I/G bit: LSB of the first octet on the wire.
    function automatic logic is_mcast(input logic [MAC_W-1:0] mac);
        return mac[40];
    endfunction

endpackage

// File: rtl/eth_frame_filter_axis_skid_reg.sv
// Two-entry AXI-stream register slice with a registered, full-throughput ready.
// Beat = {tuser, tlast, tkeep, tdata}; the temp entry absorbs one beat on a stall.
module axis_skid_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0] m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tuser,
    output logic                  m_tvalid,
    input  logic                  m_tready
);

    localparam int W = DATA_WIDTH + KEEP_WIDTH + 2;

    logic [W-1:0] in_w;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] tmp_q, tmp_d;
    logic         out_vld_q, out_vld_d;
    logic         tmp_vld_q, tmp_vld_d;
    logic         rdy_q, rdy_d;

    assign in_w = {s_tuser, s_tlast, s_tkeep, s_tdata};

    // Only stay ready if the temp entry is guaranteed free next cycle.
    assign rdy_d = m_tready || (!tmp_vld_q && (!out_vld_q || !s_tvalid));

    always_comb begin
        out_d     = out_q;
        tmp_d     = tmp_q;
        out_vld_d = out_vld_q;
        tmp_vld_d = tmp_vld_q;
        if (rdy_q) begin
            if (m_tready || !out_vld_q) begin
                out_d     = in_w;
                out_vld_d = s_tvalid;
            end else begin
                tmp_d     = in_w;
                tmp_vld_d = s_tvalid;
            end
        end else if (m_tready) begin
            out_d     = tmp_q;
            out_vld_d = tmp_vld_q;
            tmp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            tmp_q     <= '0;
            out_vld_q <= 1'b0;
            tmp_vld_q <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            tmp_q     <= tmp_d;
            out_vld_q <= out_vld_d;
            tmp_vld_q <= tmp_vld_d;
            rdy_q     <= rdy_d;
        end
    end

    assign s_tready = rdy_q;
    assign m_tvalid = out_vld_q;
    assign {m_tuser, m_tlast, m_tkeep, m_tdata} = out_q;

endmodule

// File: rtl/eth_frame_filter.sv
// Destination-MAC filter between the Ethernet receiver and the stack.
// Matching frames pass through; others are swallowed and counted.
module eth_frame_filter
    import eth_frame_filter_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter bit KEEP_ENABLE  = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter bit BCAST_ENABLE = 1'b1,
    parameter bit MCAST_ENABLE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,
    input  logic [47:0]           local_mac,
    input  logic                  cfg_promisc,
    output logic [31:0]           drop_count,
    output logic                  busy
);

    if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_bad_keep
        $error("eth_frame_filter: KEEP_WIDTH*8 must equal DATA_WIDTH");
    end

    filt_state_e       state_q;
    logic              hdr_rdy_q;
    logic              hdr_vld_q;
    logic [MAC_W-1:0]  dest_q, src_q;
    logic [TYPE_W-1:0] type_q;
    logic [31:0]       drop_q;

    logic                  hdr_acc, hdr_pend, match;
    logic                  in_fwd, pay_vld, skid_rdy, last_acc;
    logic [KEEP_WIDTH-1:0] skid_keep;

    assign hdr_acc  = s_eth_hdr_valid && hdr_rdy_q;
    assign hdr_pend = hdr_vld_q && !m_eth_hdr_ready;

    assign match = (s_eth_dest_mac == local_mac)
                || (BCAST_ENABLE && (s_eth_dest_mac == ETH_BCAST_MAC))
                || (MCAST_ENABLE && is_mcast(s_eth_dest_mac))
                || cfg_promisc;

    assign in_fwd   = (state_q == FORWARD);
    assign pay_vld  = s_eth_payload_axis_tvalid && in_fwd;
    assign last_acc = s_eth_payload_axis_tvalid
                   && s_eth_payload_axis_tready
                   && s_eth_payload_axis_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_rdy_q <= 1'b0;
            hdr_vld_q <= 1'b0;
            dest_q    <= '0;
            src_q     <= '0;
            type_q    <= '0;
            drop_q    <= '0;
        end else begin
            hdr_rdy_q <= 1'b0;
            hdr_vld_q <= hdr_pend;
            unique case (state_q)
                IDLE: begin
                    if (hdr_acc && match) begin
                        state_q   <= FORWARD;
                        hdr_vld_q <= 1'b1;
                        dest_q    <= s_eth_dest_mac;
                        src_q     <= s_eth_src_mac;
                        type_q    <= s_eth_type;
                    end else if (hdr_acc) begin
                        state_q <= DROP;
                        if (drop_q != 32'hFFFF_FFFF) drop_q <= drop_q + 32'd1;
                    end else begin
                        hdr_rdy_q <= !hdr_pend;
                    end
                end
                FORWARD, DROP: begin
                    if (last_acc) begin
                        state_q   <= IDLE;
                        hdr_rdy_q <= !hdr_pend;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_skid_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_eth_payload_axis_tdata),
        .s_tkeep  (s_eth_payload_axis_tkeep),
        .s_tlast  (s_eth_payload_axis_tlast),
        .s_tuser  (s_eth_payload_axis_tuser),
        .s_tvalid (pay_vld),
        .s_tready (skid_rdy),
        .m_tdata  (m_eth_payload_axis_tdata),
        .m_tkeep  (skid_keep),
        .m_tlast  (m_eth_payload_axis_tlast),
        .m_tuser  (m_eth_payload_axis_tuser),
        .m_tvalid (m_eth_payload_axis_tvalid),
        .m_tready (m_eth_payload_axis_tready)
    );

    assign s_eth_hdr_ready           = hdr_rdy_q;
    assign s_eth_payload_axis_tready = in_fwd ? skid_rdy : (state_q == DROP);
    assign m_eth_payload_axis_tkeep  = KEEP_ENABLE ? skid_keep : '1;

    assign m_eth_hdr_valid = hdr_vld_q;
    assign m_eth_dest_mac  = dest_q;
    assign m_eth_src_mac   = src_q;
    assign m_eth_type      = type_q;
    assign drop_count      = drop_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_eth_frame_filter.sv
// Directed bench for eth_frame_filter: forward/drop, stalls, ordering, reset.
// A second instance with broadcast disabled covers the BCAST_ENABLE=0 case.
module tb_eth_frame_filter;

    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SMAC  = 48'h02_00_00_00_00_AA;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_hdr_valid = 1'b0, s_hdr_ready;
    logic [47:0] s_dest = '0, s_src = '0;
    logic [15:0] s_type = '0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '1;
    logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
    logic        m_hdr_valid, m_hdr_ready = 1'b1;
    logic [47:0] m_dest, m_src;
    logic [15:0] m_type;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
    logic [47:0] local_mac = LMAC;
    logic        promisc = 1'b0;
    logic [31:0] drop_count;
    logic        busy;

    logic        b_hdr_valid = 1'b0, b_hdr_ready;
    logic        b_tvalid = 1'b0, b_tready;
    logic        b_m_hdr_valid, b_m_tvalid, b_m_tlast, b_m_tuser, b_busy;
    logic [47:0] b_m_dest, b_m_src;
    logic [15:0] b_m_type;
    logic [63:0] b_m_tdata;
    logic [7:0]  b_m_tkeep;
    logic [31:0] b_drop_count;

    int checks = 0;
    int failures = 0;

    logic [111:0] rh_q[$], eh_q[$];
    logic [65:0]  rx_q[$], ex_q[$];

    always #5 clk = ~clk;

    eth_frame_filter u_dut (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(s_hdr_valid), .s_eth_hdr_ready(s_hdr_ready),
        .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
        .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
        .s_eth_payload_axis_tvalid(s_tvalid), .s_eth_payload_axis_tready(s_tready),
        .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
        .m_eth_hdr_valid(m_hdr_valid), .m_eth_hdr_ready(m_hdr_ready),
        .m_eth_dest_mac(m_dest), .m_eth_src_mac(m_src), .m_eth_type(m_type),
        .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tkeep(m_tkeep),
        .m_eth_payload_axis_tvalid(m_tvalid), .m_eth_payload_axis_tready(m_tready),
        .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
        .local_mac(local_mac), .cfg_promisc(promisc),
        .drop_count(drop_count), .busy(busy)
    );

    eth_frame_filter #(.BCAST_ENABLE(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(b_hdr_valid), .s_eth_hdr_ready(b_hdr_ready),
        .s_eth_dest_mac(s_dest), .s_eth_src_mac(s_src), .s_eth_type(s_type),
        .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tkeep(s_tkeep),
        .s_eth_payload_axis_tvalid(b_tvalid), .s_eth_payload_axis_tready(b_tready),
        .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
        .m_eth_hdr_valid(b_m_hdr_valid), .m_eth_hdr_ready(1'b1),
        .m_eth_dest_mac(b_m_dest), .m_eth_src_mac(b_m_src), .m_eth_type(b_m_type),
        .m_eth_payload_axis_tdata(b_m_tdata), .m_eth_payload_axis_tkeep(b_m_tkeep),
        .m_eth_payload_axis_tvalid(b_m_tvalid), .m_eth_payload_axis_tready(1'b1),
        .m_eth_payload_axis_tlast(b_m_tlast), .m_eth_payload_axis_tuser(b_m_tuser),
        .local_mac(local_mac), .cfg_promisc(promisc),
        .drop_count(b_drop_count), .busy(b_busy)
    );

    always @(negedge clk) begin
        if (m_tvalid && m_tready) rx_q.push_back({m_tuser, m_tlast, m_tdata});
        if (m_hdr_valid && m_hdr_ready) rh_q.push_back({m_dest, m_src, m_type});
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_hdr(input logic [47:0] d);
        logic acc;
        acc = 1'b0;
        s_dest = d;
        s_src = SMAC;
        s_type = 16'h0800;
        s_hdr_valid = 1'b1;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge clk);
            acc = s_hdr_ready;
            @(posedge clk);
            #1;
        end
        s_hdr_valid = 1'b0;
        check("hdr_accept", 64'(acc), 64'd1);
    endtask

    task automatic send_pay(input int n, input logic [63:0] base,
                            input logic user, input logic dolast,
                            output int cyc, output logic busy_l);
        logic acc;
        cyc = 0;
        busy_l = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            s_tdata = base + 64'(i);
            s_tlast = dolast && (i == n - 1);
            s_tuser = user && (i == n - 1);
            s_tvalid = 1'b1;
            while (!acc && cyc < 200) begin
                @(negedge clk);
                acc = s_tready;
                busy_l = busy;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        check("pay_bound", 64'(cyc < 200), 64'd1);
    endtask

    task automatic expect_frame(input logic [47:0] d, input int n,
                                input logic [63:0] base, input logic user);
        eh_q.push_back({d, SMAC, 16'h0800});
        for (int i = 0; i < n; i++)
            ex_q.push_back({user && (i == n - 1), 1'b1 && (i == n - 1),
                            base + 64'(i)});
    endtask

    task automatic compare_all(input string tag);
        logic [111:0] h, eh;
        logic [65:0]  b, eb;
        tick(6);
        check({tag, "_nhdr"}, 64'(rh_q.size()), 64'(eh_q.size()));
        check({tag, "_nbeat"}, 64'(rx_q.size()), 64'(ex_q.size()));
        while (rh_q.size() > 0 && eh_q.size() > 0) begin
            h = rh_q.pop_front();
            eh = eh_q.pop_front();
            check({tag, "_dest"}, 64'(h[111:64]), 64'(eh[111:64]));
            check({tag, "_srctype"}, h[63:0], eh[63:0]);
        end
        while (rx_q.size() > 0 && ex_q.size() > 0) begin
            b = rx_q.pop_front();
            eb = ex_q.pop_front();
            check({tag, "_data"}, b[63:0], eb[63:0]);
            check({tag, "_lastuser"}, 64'(b[65:64]), 64'(eb[65:64]));
        end
        rh_q.delete();
        eh_q.delete();
        rx_q.delete();
        ex_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   cyc;
        logic bl;
        logic acc;

        tick(3);
        check("rst_hdr_ready", 64'(s_hdr_ready), 64'd0);
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_m_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        rst = 1'b0;
        tick(2);

        // 1: unicast match, three beats
        send_hdr(LMAC);
        check("t1_hdr_lat", 64'(m_hdr_valid), 64'd1);
        check("t1_type", 64'(m_type), 64'h0800);
        expect_frame(LMAC, 3, 64'h1000, 1'b0);
        send_pay(3, 64'h1000, 1'b0, 1'b1, cyc, bl);
        check("t1_cycles", 64'(cyc), 64'd3);
        compare_all("t1");
        check("t1_drop", 64'(drop_count), 64'd0);

        // 2: unicast miss
        send_hdr(48'h02_00_00_00_00_99);
        check("t2_drop", 64'(drop_count), 64'd1);
        check("t2_busy", 64'(busy), 64'd1);
        send_pay(3, 64'h2000, 1'b0, 1'b1, cyc, bl);
        check("t2_cycles", 64'(cyc), 64'd3);
        check("t2_busy_last", 64'(bl), 64'd1);
        check("t2_busy_after", 64'(busy), 64'd0);
        compare_all("t2");

        // 3: broadcast, errored frame still forwarded
        send_hdr(BCAST);
        expect_frame(BCAST, 2, 64'h3000, 1'b1);
        send_pay(2, 64'h3000, 1'b1, 1'b1, cyc, bl);
        compare_all("t3");
        check("t3_drop", 64'(drop_count), 64'd1);

        // 3b: broadcast on the instance with broadcast disabled
        s_dest = BCAST;
        b_hdr_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = b_hdr_ready;
            @(posedge clk);
            #1;
        end
        b_hdr_valid = 1'b0;
        check("t3b_hdr_accept", 64'(acc), 64'd1);
        check("t3b_drop", 64'(b_drop_count), 64'd1);
        s_tdata = 64'h3B00;
        s_tlast = 1'b1;
        b_tvalid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = b_tready;
            @(posedge clk);
            #1;
        end
        b_tvalid = 1'b0;
        s_tlast = 1'b0;
        check("t3b_pay_accept", 64'(acc), 64'd1);
        check("t3b_busy", 64'(b_busy), 64'd0);
        check("t3b_no_hdr", 64'(b_m_hdr_valid), 64'd0);

        // multicast with MCAST disabled: one-beat drop
        send_hdr(48'h01_00_5E_00_00_01);
        send_pay(1, 64'h3C00, 1'b0, 1'b1, cyc, bl);
        compare_all("mcast");
        check("mcast_drop", 64'(drop_count), 64'd2);

        // promiscuous: one-beat forward of a foreign unicast
        promisc = 1'b1;
        send_hdr(48'h0A_0B_0C_0D_0E_0F);
        promisc = 1'b0;
        expect_frame(48'h0A_0B_0C_0D_0E_0F, 1, 64'h3D00, 1'b0);
        send_pay(1, 64'h3D00, 1'b0, 1'b1, cyc, bl);
        compare_all("promisc");

        // 4: output ready toggling every cycle over 8 beats
        send_hdr(LMAC);
        expect_frame(LMAC, 8, 64'h4000, 1'b0);
        fork
            send_pay(8, 64'h4000, 1'b0, 1'b1, cyc, bl);
            begin
                repeat (24) begin
                    @(posedge clk);
                    #1;
                    m_tready = ~m_tready;
                end
                m_tready = 1'b1;
            end
        join
        compare_all("t4");

        // 5: match, drop, match with the first header held
        m_hdr_ready = 1'b0;
        send_hdr(LMAC);
        fork
            begin
                tick(4);
                m_hdr_ready = 1'b1;
            end
        join_none
        expect_frame(LMAC, 2, 64'h5000, 1'b0);
        send_pay(2, 64'h5000, 1'b0, 1'b1, cyc, bl);
        send_hdr(48'h02_00_00_00_00_77);
        check("t5_hdr_order", 64'(rh_q.size()), 64'd1);
        send_pay(2, 64'h5100, 1'b0, 1'b1, cyc, bl);
        send_hdr(LMAC);
        expect_frame(LMAC, 3, 64'h5200, 1'b0);
        send_pay(3, 64'h5200, 1'b0, 1'b1, cyc, bl);
        compare_all("t5");
        check("t5_drop", 64'(drop_count), 64'd3);

        // 6: asynchronous reset in the middle of a forwarded frame
        m_hdr_ready = 1'b0;
        m_tready = 1'b0;
        send_hdr(LMAC);
        send_pay(2, 64'h6000, 1'b0, 1'b0, cyc, bl);
        #2;
        rst = 1'b1;
        #1;
        check("t6_m_hdr_valid", 64'(m_hdr_valid), 64'd0);
        check("t6_m_tvalid", 64'(m_tvalid), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_tready", 64'(s_tready), 64'd0);
        check("t6_drop", 64'(drop_count), 64'd0);
        check("t6_m_dest", 64'(m_dest), 64'd0);
        check("t6_m_tdata", m_tdata, 64'd0);
        tick(1);
        rst = 1'b0;
        rh_q.delete();
        rx_q.delete();
        m_hdr_ready = 1'b1;
        m_tready = 1'b1;
        tick(2);
        send_hdr(LMAC);
        expect_frame(LMAC, 3, 64'h6100, 1'b0);
        send_pay(3, 64'h6100, 1'b0, 1'b1, cyc, bl);
        compare_all("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
